// File: rtl/bitonic_unloader_if.sv
// Result stream from the bitonic unloader to the narrow result sink.
// The master drives data/valid/last; the slave drives ready.
interface bitonic_unloader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/bitonic_unloader.sv
// Captures the sorter's packed result on done_in and streams its elements one per cycle
// over a valid/ready interface, with overrun detection for vectors arriving mid-stream.
module bitonic_unloader #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_DEPTH = 1,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [(2**BLOCK_DEPTH)*DATA_WIDTH-1:0]   data_in,
  input  logic                                     done_in,
  bitonic_unloader_if.master                       out_if,
  output logic                                     busy,
  output logic                                     overrun
);

  localparam int N  = 2 ** BLOCK_DEPTH;
  localparam int IW = (BLOCK_DEPTH > 0) ? BLOCK_DEPTH : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_STREAM     = 2'd1,
    ST_WAIT_CLEAR = 2'd2
  } state_t;

  state_t                      state_reg, state_next;
  logic [IW-1:0]               index_reg, index_next;
  logic [N*DATA_WIDTH-1:0]     shadow_reg, shadow_next;
  logic                        done_q_reg;
  logic [DATA_WIDTH-1:0]       out_data_reg, out_data_next;
  logic                        out_valid_reg, out_valid_next;
  logic                        out_last_reg, out_last_next;
  logic                        busy_reg, busy_next;
  logic                        overrun_reg, overrun_next;

  logic                        capture;
  logic                        transfer;
  logic [IW-1:0]               sel;
  logic [DATA_WIDTH-1:0]       elem_next;
  logic [DATA_WIDTH-1:0]       in_elem   [N];
  logic [DATA_WIDTH-1:0]       hold_elem [N];

  // Element views of the incoming vector and of the captured copy.
  for (genvar gi = 0; gi < N; gi++) begin : g_elem
    assign in_elem[gi]   = data_in[DATA_WIDTH*gi +: DATA_WIDTH];
    assign hold_elem[gi] = shadow_reg[DATA_WIDTH*gi +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      index_reg     <= '0;
      shadow_reg    <= '0;
      done_q_reg    <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      index_reg     <= index_next;
      shadow_reg    <= shadow_next;
      done_q_reg    <= done_in;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      busy_reg      <= busy_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    index_next  = index_reg;
    shadow_next = shadow_reg;
    capture     = 1'b0;
    transfer    = out_valid_reg & out_if.out_ready;

    case (state_reg)
      ST_IDLE: begin
        if (done_in) begin
          capture     = 1'b1;
          shadow_next = data_in;
          index_next  = '0;
          state_next  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (transfer) begin
          if (index_reg == LAST_IDX) begin
            // A still-high done means this vector is stale; wait for it to clear.
            state_next = done_in ? ST_WAIT_CLEAR : ST_IDLE;
          end else begin
            index_next = index_reg + IW'(1);
          end
        end
      end
      ST_WAIT_CLEAR: begin
        if (!done_in) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-cycle view;
    // on capture the new element comes straight from data_in.
    sel       = LSB_FIRST ? index_next : (LAST_IDX - index_next);
    elem_next = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == IW'(i)) elem_next = capture ? in_elem[i] : hold_elem[i];
    end

    out_valid_next = (state_next == ST_STREAM);
    out_data_next  = out_valid_next ? elem_next : '0;
    out_last_next  = out_valid_next && (index_next == LAST_IDX);
    busy_next      = (state_next != ST_IDLE);
    overrun_next   = (state_reg == ST_STREAM) && done_in && !done_q_reg;
  end

  assign out_if.out_data  = out_data_reg;
  assign out_if.out_valid = out_valid_reg;
  assign out_if.out_last  = out_last_reg;
  assign busy             = busy_reg;
  assign overrun          = overrun_reg;

endmodule

// File: tb/tb_bitonic_unloader.sv
// Bench for bitonic_unloader: three configurations share one stimulus stream and are
// compared each cycle against a vector-list reference model.
module tb_bitonic_unloader;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic        ready;
  logic [31:0] data_in;

  logic busy_a, busy_b, busy_c;
  logic ovr_a, ovr_b, ovr_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bitonic_unloader_if #(.DATA_WIDTH(8)) if_a ();
  bitonic_unloader_if #(.DATA_WIDTH(8)) if_b ();
  bitonic_unloader_if #(.DATA_WIDTH(8)) if_c ();

  assign if_a.out_ready = ready;
  assign if_b.out_ready = ready;
  assign if_c.out_ready = ready;

  bitonic_unloader #(.DATA_WIDTH(8), .BLOCK_DEPTH(2), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(rst), .data_in(data_in), .done_in(done),
    .out_if(if_a.master), .busy(busy_a), .overrun(ovr_a));

  bitonic_unloader #(.DATA_WIDTH(8), .BLOCK_DEPTH(2), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(rst), .data_in(data_in), .done_in(done),
    .out_if(if_b.master), .busy(busy_b), .overrun(ovr_b));

  bitonic_unloader #(.DATA_WIDTH(8), .BLOCK_DEPTH(0), .LSB_FIRST(1'b1)) dut_c (
    .clk(clk), .reset(rst), .data_in(data_in[7:0]), .done_in(done),
    .out_if(if_c.master), .busy(busy_c), .overrun(ovr_c));

  logic [7:0] o_data  [3];
  logic       o_valid [3];
  logic       o_last  [3];
  logic       o_busy  [3];
  logic       o_ovr   [3];

  always_comb begin
    o_data[0] = if_a.out_data; o_valid[0] = if_a.out_valid; o_last[0] = if_a.out_last;
    o_data[1] = if_b.out_data; o_valid[1] = if_b.out_valid; o_last[1] = if_b.out_last;
    o_data[2] = if_c.out_data; o_valid[2] = if_c.out_valid; o_last[2] = if_c.out_last;
    o_busy[0] = busy_a; o_busy[1] = busy_b; o_busy[2] = busy_c;
    o_ovr[0]  = ovr_a;  o_ovr[1]  = ovr_b;  o_ovr[2]  = ovr_c;
  end

  // Reference: a captured vector is a list in send order; pos counts elements already sent.
  int         m_n   [3] = '{4, 4, 1};
  bit         m_lsb [3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] m_list [3][4];
  int         m_pos [3];
  bit         m_active [3];
  bit         m_wait [3];
  bit         m_prev [3];
  bit         m_ovr  [3];

  task automatic model_step(input int k);
    int e;
    if (rst) begin
      m_active[k] = 1'b0; m_wait[k] = 1'b0; m_prev[k] = 1'b0; m_ovr[k] = 1'b0; m_pos[k] = 0;
    end else begin
      m_ovr[k] = m_active[k] && done && !m_prev[k];
      if (m_active[k]) begin
        if (ready) begin
          m_pos[k]++;
          if (m_pos[k] == m_n[k]) begin
            m_active[k] = 1'b0;
            m_wait[k]   = done;
          end
        end
      end else if (m_wait[k]) begin
        if (!done) m_wait[k] = 1'b0;
      end else if (done) begin
        for (int j = 0; j < m_n[k]; j++) begin
          e = m_lsb[k] ? j : (m_n[k] - 1 - j);
          m_list[k][j] = data_in[8*e +: 8];
        end
        m_pos[k]    = 0;
        m_active[k] = 1'b1;
      end
      m_prev[k] = done;
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic cycle(input logic d, input logic r, input logic rs, input logic [31:0] din);
    logic [7:0] exp_data;
    done = d; ready = r; rst = rs; data_in = din;
    if (!rs) begin
      for (int k = 0; k < 3; k++) begin
        if (o_valid[k] === 1'b1 && r)
          $display("xfer dut%0d data=%02h last=%0b", k, o_data[k], o_last[k]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_data = m_active[k] ? m_list[k][m_pos[k]] : 8'h00;
      chk("out_valid", k, {7'd0, o_valid[k]}, {7'd0, m_active[k]});
      chk("out_data",  k, o_data[k], exp_data);
      chk("out_last",  k, {7'd0, o_last[k]}, {7'd0, m_active[k] && (m_pos[k] == m_n[k] - 1)});
      chk("busy",      k, {7'd0, o_busy[k]}, {7'd0, m_active[k] || m_wait[k]});
      chk("overrun",   k, {7'd0, o_ovr[k]},  {7'd0, m_ovr[k]});
    end
  endtask

  localparam logic [31:0] VEC1 = 32'h40302010;
  localparam logic [31:0] VEC2 = 32'hD4C3B2A1;

  initial begin
    // Reset state
    cycle(0, 0, 1, 32'h0);
    cycle(0, 0, 1, 32'h0);

    // One-cycle done pulse, sink always ready
    cycle(1, 1, 0, VEC1);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 32'h0);

    // Ready toggling: elements held while ready is low
    cycle(1, 1, 0, VEC1);
    for (int i = 0; i < 10; i++) cycle(0, (i % 2) == 0, 0, 32'h0);

    // done held high: one stream, then wait for done to clear, then a fresh pulse
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, VEC1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 32'h0);
    cycle(1, 1, 0, VEC2);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 32'h0);

    // Overrun: a new done edge at element 2 while the sink stalls
    cycle(1, 1, 0, VEC1);
    cycle(0, 1, 0, 32'h0);
    cycle(0, 1, 0, 32'h0);
    cycle(1, 0, 0, VEC2);
    cycle(0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 32'h0);

    // Reset mid-stream, then restart from element 0
    cycle(1, 1, 0, VEC1);
    cycle(0, 1, 0, 32'h0);
    cycle(0, 1, 1, 32'h0);
    cycle(1, 1, 0, VEC2);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 32'h0);

    // Single-element vector content
    cycle(1, 1, 0, 32'h000000A5);
    cycle(1, 1, 0, 32'h000000A5);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) == 0, $urandom);
    end
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
